// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. It feeds one operand bit pair per cycle, LSB first,
// into an external 1-bit full adder and collects the sum in a shift register.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_sum,
    input  logic             fa_carry,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // The bit that would leave the bottom of the partial sum is never needed,
    // so only the upper WIDTH-1 bits are kept.
    logic [WIDTH-2:0] s_sr;
    logic             c_reg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] s_next;

    assign s_next = {fa_sum, s_sr};

    assign fa_a = (state == RUN) && a_sr[0];
    assign fa_b = (state == RUN) && b_sr[0];
    assign fa_c = (state == RUN) && c_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            s_sr    <= '0;
            c_reg   <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum_out <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a_in;
                        b_sr  <= b_in;
                        s_sr  <= '0;
                        c_reg <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                    s_sr  <= s_next[WIDTH-1:1];
                    c_reg <= fa_carry;
                    // The counter stops at the last bit so it never wraps.
                    if (cnt == LAST_BIT) begin
                        sum_out <= s_next;
                        cout    <= fa_carry;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: an 8-bit instance for directed sequences and a 4-bit
// instance for an exhaustive sweep, each wired to a behavioural full adder.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;

    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       fa_a8, fa_b8, fa_c8, fa_sum8, fa_carry8, busy8, done8, cout8;

    logic       start4 = 1'b0, cin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    logic       fa_a4, fa_b4, fa_c4, fa_sum4, fa_carry4, busy4, done4, cout4;

    int n_chk = 0;
    int n_fail = 0;
    int done_cnt8 = 0;
    int done_cnt4 = 0;

    logic [8:0] q8[$];
    logic [4:0] q4[$];
    logic [8:0] e8;
    logic [4:0] e4;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       c;
        logic       repulse;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    assign fa_sum8   = fa_a8 ^ fa_b8 ^ fa_c8;
    assign fa_carry8 = (fa_a8 & fa_b8) | (fa_a8 & fa_c8) | (fa_b8 & fa_c8);
    assign fa_sum4   = fa_a4 ^ fa_b4 ^ fa_c4;
    assign fa_carry4 = (fa_a4 & fa_b4) | (fa_a4 & fa_c4) | (fa_b4 & fa_c4);

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
        .fa_a(fa_a8), .fa_b(fa_b8), .fa_c(fa_c8), .fa_sum(fa_sum8), .fa_carry(fa_carry8),
        .busy(busy8), .done(done8), .sum_out(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a_in(a4), .b_in(b4), .cin(cin4),
        .fa_a(fa_a4), .fa_b(fa_b4), .fa_c(fa_c4), .fa_sum(fa_sum4), .fa_carry(fa_carry4),
        .busy(busy4), .done(done4), .sum_out(sum4), .cout(cout4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h", nm, act, req);
        end
    endtask

    // Scoreboards: pop the expected result whenever a done pulse is seen.
    always @(negedge clk) begin
        if (done8) begin
            done_cnt8++;
            chk("sb8_pending", 32'(q8.size() != 0), 32'd1);
            if (q8.size() != 0) begin
                e8 = q8.pop_front();
                chk("result8", 32'({cout8, sum8}), 32'(e8));
            end
        end
        if (done4) begin
            done_cnt4++;
            chk("sb4_pending", 32'(q4.size() != 0), 32'd1);
            if (q4.size() != 0) begin
                e4 = q4.pop_front();
                chk("result4", 32'({cout4, sum4}), 32'(e4));
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int bc;
        int d0;
        @(posedge clk); #1;
        a8 = v.a; b8 = v.b; cin8 = v.cin; start8 = 1'b1;
        q8.push_back({v.c, v.s});
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("first_fa_a", 32'(fa_a8), 32'(v.a[0]));
        chk("first_fa_b", 32'(fa_b8), 32'(v.b[0]));
        chk("first_fa_c", 32'(fa_c8), 32'(v.cin));
        chk("first_busy", 32'(busy8), 32'd1);
        bc = 0;
        d0 = done_cnt8;
        for (int k = 0; k < 30 && done_cnt8 == d0; k++) begin
            @(negedge clk); #1;
            if (busy8) bc++;
            if (v.repulse) start8 = (k == 2);
        end
        start8 = 1'b0;
        chk("done_seen", 32'(done_cnt8 - d0), 32'd1);
        chk("busy_cycles", 32'(bc), 32'd8);
        repeat (2) @(negedge clk);
        #1;
        chk("done_once", 32'(done_cnt8 - d0), 32'd1);
        chk("idle_after", 32'(busy8), 32'd0);
        chk("result_hold", 32'({cout8, sum8}), 32'({v.c, v.s}));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int d1;
        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0};
        vecs[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_sum", 32'(sum8), 32'd0);
        chk("rst_cout", 32'(cout8), 32'd0);
        chk("rst_fa", 32'({fa_a8, fa_b8, fa_c8}), 32'd0);
        chk("rst_busy4", 32'(busy4), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Start held high across two back-to-back operations.
        @(posedge clk); #1;
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back(9'h002);
        d0 = done_cnt8;
        for (int k = 0; k < 30 && done_cnt8 == d0; k++) begin
            @(negedge clk); #1;
        end
        chk("held_done1", 32'(done_cnt8 - d0), 32'd1);
        a8 = 8'h80; b8 = 8'h80;
        q8.push_back(9'h100);
        @(negedge clk); #1;
        chk("held_idle_gap", 32'(busy8), 32'd0);
        @(negedge clk); #1;
        chk("held_restart", 32'(busy8), 32'd1);
        start8 = 1'b0;
        d1 = done_cnt8;
        for (int k = 0; k < 30 && done_cnt8 == d1; k++) begin
            if (busy8) chk("held_sum_hold", 32'(sum8), 32'h02);
            @(negedge clk); #1;
        end
        chk("held_done2", 32'(done_cnt8 - d1), 32'd1);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Asynchronous reset in the middle of RUN bit 3.
        d0 = done_cnt8;
        @(posedge clk); #1;
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_fa_a", 32'(fa_a8), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy8), 32'd0);
        chk("arst_done", 32'(done8), 32'd0);
        chk("arst_sum", 32'(sum8), 32'd0);
        chk("arst_cout", 32'(cout8), 32'd0);
        chk("arst_fa", 32'({fa_a8, fa_b8, fa_c8}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        #1;
        chk("arst_no_done", 32'(done_cnt8 - d0), 32'd0);
        chk("arst_idle", 32'(busy8), 32'd0);

        // Exhaustive 4-bit sweep.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    @(posedge clk); #1;
                    a4 = 4'(a); b4 = 4'(b); cin4 = c[0]; start4 = 1'b1;
                    q4.push_back(5'(a + b + c));
                    @(posedge clk); #1;
                    start4 = 1'b0;
                    d0 = done_cnt4;
                    for (int k = 0; k < 20 && done_cnt4 == d0; k++) begin
                        @(negedge clk); #1;
                    end
                    chk("done4_seen", 32'(done_cnt4 - d0), 32'd1);
                end
            end
        end

        repeat (3) @(negedge clk);
        chk("sb8_empty", 32'(q8.size()), 32'd0);
        chk("sb4_empty", 32'(q4.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
